// File: rtl/mem_arbiter_pkg.sv
// Shared pipeline defines for the memory arbiter.
// Holds the arbiter FSM encodings and the default starvation limit.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2
  } arb_state_e;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// Fetch starvation guard.
// Counts data grants that were accepted while fetch was waiting. Once the
// count reaches STARVE_MAX, fetch is given priority on the next pick.
module arb_starve_ctr #(
  parameter int STARVE_MAX = mem_arbiter_pkg::STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic dm_accept_i,
  input  logic if_accept_i,
  input  logic if_req_i,
  output logic force_fetch_o
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear on fetch grant or when fetch is not waiting, else saturate up
  always_comb begin
    cnt_d = cnt_q;
    if (!if_req_i || if_accept_i) begin
      cnt_d = '0;
    end else if (dm_accept_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign force_fetch_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch / memory-stage arbiter for a single-port unified memory.
// Data accesses win unless fetch has been starved STARVE_MAX times.
// Optional stall performance counters: define MEM_ARBITER_PERF_EN.
//
// state   | meaning
// IDLE    | no read outstanding, may issue a request
// IF_WAIT | fetch read accepted, waiting for mem_rvalid_i
// DM_WAIT | data read accepted, waiting for mem_rvalid_i
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_rvalid_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  input  logic [3:0]        dm_strb_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_rvalid_o,
  output logic              dm_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_strb_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic [31:0]       if_stall_cnt_o,
  output logic [31:0]       dm_stall_cnt_o
);

  arb_state_e state_q, state_d;
  logic       drop_q, drop_d;
  logic       force_fetch;
  logic       pick_if, pick_dm;
  logic       if_acc, dm_acc, dm_wr_acc;
  logic       if_ret, dm_ret;

  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk           (clk),
    .reset         (reset),
    .dm_accept_i   (dm_acc),
    .if_accept_i   (if_acc),
    .if_req_i      (if_req_i),
    .force_fetch_o (force_fetch)
  );

  // Pick, issue mux, next state and response outputs
  always_comb begin
    pick_if     = (state_q == IDLE) && if_req_i && !if_flush_i && (!dm_req_i || force_fetch);
    pick_dm     = (state_q == IDLE) && !pick_if && dm_req_i;
    if_acc      = pick_if && mem_ready_i;
    dm_acc      = pick_dm && mem_ready_i;
    dm_wr_acc   = dm_acc && dm_we_i;
    if_ret      = (state_q == IF_WAIT) && mem_rvalid_i;
    dm_ret      = (state_q == DM_WAIT) && mem_rvalid_i;

    mem_req_o   = pick_if || pick_dm;
    mem_we_o    = pick_dm && dm_we_i;
    mem_addr_o  = pick_if ? if_addr_i : (pick_dm ? dm_addr_i : '0);
    mem_wdata_o = pick_dm ? dm_wdata_i : '0;
    mem_strb_o  = pick_dm ? dm_strb_i : '0;

    if_rvalid_o = if_ret && !drop_q;
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    dm_rvalid_o = dm_ret;
    dm_rdata_o  = dm_ret ? mem_rdata_i : '0;
    if_stall_o  = if_req_i && !if_rvalid_o;
    dm_stall_o  = dm_req_i && !dm_wr_acc && !dm_ret;

    state_d = state_q;
    drop_d  = drop_q;
    unique case (state_q)
      IDLE: begin
        if (if_acc) begin
          state_d = IF_WAIT;
          drop_d  = if_flush_i;
        end else if (dm_acc && !dm_we_i) begin
          state_d = DM_WAIT;
        end
      end
      IF_WAIT: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end else if (if_flush_i) begin
          drop_d  = 1'b1;
        end
      end
      DM_WAIT: begin
        if (mem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and drop flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] if_cnt_q, if_cnt_d, dm_cnt_q, dm_cnt_d;

  // Saturating stall-cycle counters
  always_comb begin
    if_cnt_d = if_cnt_q;
    dm_cnt_d = dm_cnt_q;
    if (if_stall_o && (if_cnt_q != 32'hFFFF_FFFF)) if_cnt_d = if_cnt_q + 32'd1;
    if (dm_stall_o && (dm_cnt_q != 32'hFFFF_FFFF)) dm_cnt_d = dm_cnt_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      if_cnt_q <= '0;
      dm_cnt_q <= '0;
    end else begin
      if_cnt_q <= if_cnt_d;
      dm_cnt_q <= dm_cnt_d;
    end
  end

  assign if_stall_cnt_o = if_cnt_q;
  assign dm_stall_cnt_o = dm_cnt_q;
`else
  assign if_stall_cnt_o = '0;
  assign dm_stall_cnt_o = '0;
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one single-port unified instruction/data memory between the fetch stage and the memory stage of the 5-stage MIPS pipeline. Memory-stage accesses win by default. A starvation counter guarantees fetch forward progress. Per-requester stall outputs feed the hazard unit, and a flush input discards an in-flight fetch after a branch or jump redirect.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; one clock, rising edge
- if_req_i  in  1  fetch read request, level, held while if_stall_o
- if_addr_i  in  ADDR_W  fetch address
- if_flush_i  in  1  discard pending/in-flight fetch result
- if_rdata_o  out  DATA_W  fetched instruction
- if_rvalid_o  out  1  one-cycle pulse, if_rdata_o valid
- if_stall_o  out  1  fetch must hold
- dm_req_i  in  1  data request, level, held while dm_stall_o
- dm_we_i  in  1  1 = write
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  write data
- dm_strb_i  in  4  byte strobes
- dm_rdata_o  out  DATA_W  load data
- dm_rvalid_o  out  1  one-cycle pulse, dm_rdata_o valid
- dm_stall_o  out  1  memory stage must hold
- mem_req_o, mem_we_o  out  1  memory request / write
- mem_addr_o  out  ADDR_W; mem_wdata_o  out  DATA_W; mem_strb_o  out  4
- mem_ready_i  in  1  memory accepts request this cycle
- mem_rdata_i  in  DATA_W; mem_rvalid_i  in  1  read return, ≥1 cycle after accept
- if_stall_cnt_o, dm_stall_cnt_o  out  32  perf counters (see Configuration)

## Operation
- FSM states: IDLE, IF_WAIT, DM_WAIT. Only one read is outstanding at a time.
- IDLE pick:
  - Fetch wins if if_req_i & ~if_flush_i & (~dm_req_i | starve_cnt == STARVE_MAX).
  - Otherwise data wins if dm_req_i.
- Issue rules:
  - mem_req_o is asserted only in IDLE with a pick. Address, data and strobe are muxed from the winner.
  - The issue counts only when mem_ready_i = 1.
  - If mem_ready_i = 0, the request is re-arbitrated next cycle with no state change.
- Data write accepted: completes in the same cycle, dm_stall_o = 0 that cycle, FSM stays IDLE.
- Data read accepted → DM_WAIT. Fetch accepted → IF_WAIT.
- DM_WAIT:
  - On mem_rvalid_i: dm_rdata_o = mem_rdata_i, dm_rvalid_o = 1, → IDLE.
  - No issue in the return cycle.
- IF_WAIT:
  - On mem_rvalid_i: if_rvalid_o = ~drop, → IDLE, drop cleared.
  - The drop flag is set by if_flush_i in IF_WAIT, or by if_flush_i in the accept cycle.
- Stalls (combinational):
  - if_stall_o = if_req_i & ~(IF_WAIT & mem_rvalid_i & ~drop).
  - dm_stall_o = dm_req_i & ~(write accepted) & ~(DM_WAIT & mem_rvalid_i).
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each accepted data issue while if_req_i = 1.
  - Clears on an accepted fetch issue or when if_req_i = 0.
- mem_rvalid_i in IDLE is ignored; no rvalid output is produced.
- if_flush_i in IDLE with no outstanding fetch has no effect other than suppressing the fetch pick that cycle.

## Timing
- Reset values: FSM IDLE, starve_cnt 0, drop 0, all *_rvalid_o 0, mem_req_o 0, perf counters 0.
- rdata outputs are 0 whenever the matching rvalid is 0.
- Reset mid-transaction: state returns to IDLE and any late mem_rvalid_i is ignored.
- Read latency:
  - Request to rvalid is 1 + memory latency cycles.
  - Minimum is 2: accept in cycle N, return in N+1.
- Write latency: 1 cycle, no stall if mem_ready_i = 1.
- Back-to-back reads lose one bubble cycle (return cycle, then IDLE issue).
- Simultaneous if_req_i and dm_req_i with starve_cnt < STARVE_MAX: data first.
- Same case with starve_cnt = STARVE_MAX: fetch first.

## Configuration
- MEM_ARBITER_PERF_EN defined:
  - if_stall_cnt_o counts cycles with if_stall_o = 1; dm_stall_cnt_o counts cycles with dm_stall_o = 1.
  - Both are 32-bit, saturating at 32'hFFFFFFFF, and cleared by reset.
- Undefined: both outputs are tied to 0 and no counter flops exist.

## Structure
- FSM state encodings (IDLE = 2'd0, IF_WAIT = 2'd1, DM_WAIT = 2'd2) and the STARVE_MAX default go in the shared pipeline defines header.
- One sub-module, arb_starve_ctr: saturating counter plus fetch-priority flag. Inputs are data-accept, fetch-accept and if_req_i; output is force_fetch.

## Test plan
- Reset with mem_rvalid_i = 1 pulsed in the reset cycle → all outputs 0, FSM IDLE, no rvalid after release.
- Fetch-only read, addr 0x40, memory returns 0x2402000A one cycle after accept → if_rvalid_o in cycle 2, if_stall_o high in cycle 1 only.
- Simultaneous if_req_i and dm_req_i (read 0x100), STARVE_MAX = 4 → data granted first, fetch granted after data return.
- dm_req_i write held continuously for 4 writes while if_req_i held → 5th arbitration grants fetch.
- Fetch accepted, if_flush_i pulsed in IF_WAIT, memory returns 0xDEADBEEF → no if_rvalid_o; the next fetch returns normally.
- mem_ready_i = 0 for 3 cycles with dm_req_i write → mem_req_o held, dm_stall_o = 1 for 3 cycles, write completes in cycle 4. With MEM_ARBITER_PERF_EN, dm_stall_cnt_o = 3.
